ecall_unit: RTL and testbench

Environment-call service unit for the single-cycle RISC-V core; consumes the decoder's `ecall` strobe together with the current `a7`/`a0` register values. Performs the requested I/O service: print integer, read integer from board switches, or exit. Stalls the fetch stage while a service is pending and returns results through a dedicated register-file write port into `a0`. Sits directly downstream of the instruction decoder and beside the register file.

---
 rtl/ecall_pkg.sv | 16 +
 rtl/ecall_unit_btn_debounce.sv | 37 +++
 rtl/ecall_unit.sv | 79 +++++++
 tb/tb_ecall_unit.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/ecall_pkg.sv
// ecall_pkg: service numbers and FSM state encoding shared by the ECALL service unit.
package ecall_pkg;

    localparam logic [31:0] SYS_PRINT_INT = 32'd1;
    localparam logic [31:0] SYS_READ_INT  = 32'd5;
    localparam logic [31:0] SYS_EXIT      = 32'd10;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE         = 3'd0;
    localparam state_t ST_WAIT_RELEASE = 3'd1;
    localparam state_t ST_WAIT_PRESS   = 3'd2;
    localparam state_t ST_DONE         = 3'd3;
    localparam state_t ST_HALT         = 3'd4;

endpackage

// File: rtl/ecall_unit_btn_debounce.sv
// btn_debounce: 2-flop synchronizer plus stability filter for the confirm button.
// The filter counter exists only with ECALL_DEBOUNCE_EN; otherwise level is the synchronized button.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic level
);

    logic [1:0] sync;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) sync <= '0;
        else        sync <= {sync[0], btn};

`ifdef ECALL_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CW-1:0] cnt;

    // Saturates at DEBOUNCE_CYCLES; any low sample restarts the count.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)                           cnt <= '0;
        else if (!sync[1])                    cnt <= '0;
        else if (cnt != CW'(DEBOUNCE_CYCLES)) cnt <= cnt + 1'b1;

    assign level = cnt == CW'(DEBOUNCE_CYCLES);
`else
    logic unused_cfg;

    assign unused_cfg = ^DEBOUNCE_CYCLES;
    assign level      = sync[1];
`endif

endmodule

// File: rtl/ecall_unit.sv
// ecall_unit: ECALL service unit (print int, read int from switches, exit) with fetch stall and a0 writeback.
// Button stability filtering is enabled by ECALL_DEBOUNCE_EN.
module ecall_unit
    import ecall_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int SW_W            = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ecall,
    input  logic [31:0]     a7,
    input  logic [31:0]     a0,
    input  logic [SW_W-1:0] sw_in,
    input  logic            btn_confirm,
    output logic            stall,
    output logic            wb_en,
    output logic [31:0]     wb_data,
    output logic [31:0]     seg_value,
    output logic [SW_W-1:0] led_out,
    output logic            halted
);

    state_t          state, next;
    logic [SW_W-1:0] sw_meta, sw_sync, rd_buf;
    logic            level, level_q, rise;
    logic            idle, reading, do_print, do_read, do_exit;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_confirm),
        .level (level)
    );

    assign rise     = level & ~level_q;
    assign idle     = state == ST_IDLE;
    assign reading  = state == ST_WAIT_RELEASE || state == ST_WAIT_PRESS;
    assign do_print = idle && ecall && a7 == SYS_PRINT_INT;
    assign do_read  = idle && ecall && a7 == SYS_READ_INT;
    assign do_exit  = idle && ecall && a7 == SYS_EXIT;

    always_comb begin
        next = state;
        case (state)
            ST_IDLE:         next = do_read ? ST_WAIT_RELEASE : do_exit ? ST_HALT : ST_IDLE;
            ST_WAIT_RELEASE: next = level ? ST_WAIT_RELEASE : ST_WAIT_PRESS;
            ST_WAIT_PRESS:   next = rise ? ST_DONE : ST_WAIT_PRESS;
            ST_DONE:         next = ST_IDLE;
            ST_HALT:         next = ST_HALT;
            default:         next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state     <= ST_IDLE;
            sw_meta   <= '0;
            sw_sync   <= '0;
            level_q   <= 1'b0;
            rd_buf    <= '0;
            seg_value <= '0;
        end else begin
            state     <= next;
            sw_meta   <= sw_in;
            sw_sync   <= sw_meta;
            level_q   <= level;
            rd_buf    <= (state == ST_WAIT_PRESS && rise) ? sw_sync : rd_buf;
            seg_value <= do_print ? a0 : seg_value;
        end

    // In IDLE the ECALL cycle itself must be held, so stall is combinational there.
    assign stall   = idle ? (do_read | do_exit) : (reading || state == ST_HALT);
    assign wb_en   = state == ST_DONE;
    assign wb_data = wb_en ? 32'(rd_buf) : '0;
    assign led_out = reading ? sw_sync : seg_value[SW_W-1:0];
    assign halted  = state == ST_HALT;

endmodule

// File: tb/tb_ecall_unit.sv
// tb_ecall_unit: directed self-checking bench for ecall_unit with DEBOUNCE_CYCLES=4.
module tb_ecall_unit;

    localparam int SW_W = 16;
`ifdef ECALL_DEBOUNCE_EN
    localparam bit DEB = 1'b1;
`else
    localparam bit DEB = 1'b0;
`endif

    logic            clk = 1'b0, rst_n = 1'b0, ecall = 1'b0, btn = 1'b0;
    logic [31:0]     a7 = '0, a0 = '0;
    logic [SW_W-1:0] sw = '0;
    logic            stall, wb_en, halted;
    logic [31:0]     wb_data, seg_value;
    logic [SW_W-1:0] led_out;

    int          checks = 0, failures = 0;
    int          wb_cnt = 0, stall_drops = 0, start = 0, bad = 0;
    logic [31:0] wb_last = '0;
    logic        wb_stall = 1'b0, expect_stall = 1'b0, st, seen;

    ecall_unit #(.DEBOUNCE_CYCLES(4), .SW_W(SW_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ecall       (ecall),
        .a7          (a7),
        .a0          (a0),
        .sw_in       (sw),
        .btn_confirm (btn),
        .stall       (stall),
        .wb_en       (wb_en),
        .wb_data     (wb_data),
        .seg_value   (seg_value),
        .led_out     (led_out),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wb_en) begin
            wb_cnt++;
            wb_last  = wb_data;
            wb_stall = stall;
        end else if (expect_stall && !stall) stall_drops++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic ecall_cycle(input logic [31:0] a7v, input logic [31:0] a0v, output logic s);
        ecall = 1'b1;
        a7    = a7v;
        a0    = a0v;
        #2;
        s = stall;
        @(posedge clk);
        #1;
        ecall = 1'b0;
    endtask

    task automatic press(input int n);
        btn = 1'b1;
        tick(n);
        btn = 1'b0;
    endtask

    task automatic wait_wb(input int budget, output logic s);
        int base;
        base = wb_cnt;
        s = 1'b0;
        for (int i = 0; i < budget && !s; i++) begin
            tick();
            s = wb_cnt != base;
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_stall"}, 32'(stall), 32'd0);
        check({tag, "_wb_en"}, 32'(wb_en), 32'd0);
        check({tag, "_wb_data"}, wb_data, 32'd0);
        check({tag, "_seg"}, seg_value, 32'd0);
        check({tag, "_led"}, 32'(led_out), 32'd0);
        check({tag, "_halted"}, 32'(halted), 32'd0);
    endtask

    initial begin
        tick(3);
        check_reset("reset");
        rst_n = 1'b1;
        tick(2);

        // PRINT_INT completes without stalling
        ecall_cycle(32'd1, 32'h0000_1234, st);
        check("print_stall", 32'(st), 32'd0);
        check("print_seg", seg_value, 32'h0000_1234);
        check("print_led", 32'(led_out), 32'h1234);
        check("print_no_wb", 32'(wb_cnt), 32'd0);

        // READ_INT, press after 10 cycles
        sw = 16'h00A5;
        tick(3);
        ecall_cycle(32'd5, 32'd0, st);
        check("read_stall_ecall", 32'(st), 32'd1);
        expect_stall = 1'b1;
        tick(5);
        check("read_led_mirror", 32'(led_out), 32'h00A5);
        tick(5);
        btn = 1'b1;
        wait_wb(60, seen);
        expect_stall = 1'b0;
        btn = 1'b0;
        check("read_done", 32'(seen), 32'd1);
        check("read_wb_data", wb_last, 32'h0000_00A5);
        check("read_wb_stall", 32'(wb_stall), 32'd0);
        tick(3);
        check("read_one_pulse", 32'(wb_cnt), 32'd1);
        check("read_idle_stall", 32'(stall), 32'd0);

        // Button held from before: no completion until release and re-press
        btn = 1'b1;
        tick(10);
        ecall_cycle(32'd5, 32'd0, st);
        expect_stall = 1'b1;
        wait_wb(30, seen);
        check("held_no_done", 32'(seen), 32'd0);
        check("held_stall", 32'(stall), 32'd1);
        btn = 1'b0;
        sw  = 16'h5A3C;
        tick(10);
        btn = 1'b1;
        wait_wb(60, seen);
        expect_stall = 1'b0;
        btn = 1'b0;
        check("held_done", 32'(seen), 32'd1);
        check("held_wb_data", wb_last, 32'h0000_5A3C);

        // Short glitch is filtered only when debouncing is built in
        sw = 16'hBEEF;
        tick(5);
        start = wb_cnt;
        ecall_cycle(32'd5, 32'd0, st);
        tick(10);
        press(2);
        tick(15);
        check("glitch", 32'(wb_cnt - start), DEB ? 32'd0 : 32'd1);
        press(4);
        tick(15);
        check("glitch_then_press", 32'(wb_cnt - start), 32'd1);
        check("glitch_wb_data", wb_last, 32'h0000_BEEF);
        check("stall_drops", 32'(stall_drops), 32'd0);

        // EXIT holds forever despite further ECALLs
        ecall_cycle(32'd10, 32'd0, st);
        check("exit_stall_ecall", 32'(st), 32'd1);
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            ecall = i[0];
            a7    = (i % 3 == 0) ? 32'd1 : 32'd5;
            a0    = 32'(i);
            tick();
            if (!halted || !stall) bad++;
        end
        ecall = 1'b0;
        check("halt_persist", 32'(bad), 32'd0);
        check("halt_seg", seg_value, 32'h0000_1234);
        check("halt_led", 32'(led_out), 32'h1234);
        rst_n = 1'b0;
        #2;
        check_reset("halt_reset");
        tick(2);
        rst_n = 1'b1;
        tick(2);

        // Reset during WAIT_PRESS aborts without writeback
        sw = 16'h0077;
        ecall_cycle(32'd5, 32'd0, st);
        tick(5);
        check("abort_wait_stall", 32'(stall), 32'd1);
        start = wb_cnt;
        btn = 1'b1;
        tick();
        rst_n = 1'b0;
        #2;
        check("abort_reset_stall", 32'(stall), 32'd0);
        tick(2);
        rst_n = 1'b1;
        tick(20);
        btn = 1'b0;
        tick(10);
        check("abort_no_wb", 32'(wb_cnt - start), 32'd0);
        check("abort_idle_stall", 32'(stall), 32'd0);
        check("abort_halted", 32'(halted), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
